// File: rtl/ps2_rx_frontend_if.sv
// ps2_rx_frontend_if: valid/ready code bus from the PS/2 receiver to the scan-code translator
//   CODE_DATA  set-2 code byte with prefixes stripped
//   CODE_BREAK code was preceded by F0
//   CODE_EXT   code was preceded by E0
//   CODE_VALID holding register full
//   CODE_READY consumer accepts on a rising clock edge while CODE_VALID is high
interface ps2_rx_frontend_if;
    logic [7:0] CODE_DATA;
    logic       CODE_BREAK;
    logic       CODE_EXT;
    logic       CODE_VALID;
    logic       CODE_READY;
    modport master (output CODE_DATA, CODE_BREAK, CODE_EXT, CODE_VALID, input CODE_READY);
    modport slave  (input CODE_DATA, CODE_BREAK, CODE_EXT, CODE_VALID, output CODE_READY);
endinterface

// File: rtl/ps2_rx_frontend.sv
// ps2_rx_frontend: PS/2 set-2 frame receiver folding E0/F0 prefixes into flags on a code bus
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset
//   PS2_CLK    keyboard clock line, asynchronous
//   PS2_DATA   keyboard data line, asynchronous
//   code       master side of the code holding register (data/break/ext/valid, ready in)
//   PARITY_ERR one-cycle pulse, bad parity
//   FRAME_ERR  one-cycle pulse, bad start/stop bit or inter-edge timeout
//   OVERRUN    one-cycle pulse, code dropped because the holding register was full
module ps2_rx_frontend #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 7500
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   PS2_CLK,
    input  logic                   PS2_DATA,
    ps2_rx_frontend_if.master      code,
    output logic                   PARITY_ERR,
    output logic                   FRAME_ERR,
    output logic                   OVERRUN
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic          clk_prev, fall, din, timeout;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    sh, sh_n;
    logic          par, par_n, brk, brk_n, ext, ext_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [7:0]    cdata, cdata_n;
    logic          cbrk, cbrk_n, cext, cext_n, cvalid, cvalid_n;
    logic          perr_n, ferr_n, ovr_n;
    // Sync flops reset low so a line already high after reset never looks like a falling edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end
    assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign din     = data_sync[SYNC_STAGES-1];
    assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            par        <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            tcnt       <= '0;
            cdata      <= '0;
            cbrk       <= 1'b0;
            cext       <= 1'b0;
            cvalid     <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            par        <= par_n;
            brk        <= brk_n;
            ext        <= ext_n;
            tcnt       <= tcnt_n;
            cdata      <= cdata_n;
            cbrk       <= cbrk_n;
            cext       <= cext_n;
            cvalid     <= cvalid_n;
            PARITY_ERR <= perr_n;
            FRAME_ERR  <= ferr_n;
            OVERRUN    <= ovr_n;
        end
    end
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sh_n     = sh;
        par_n    = par;
        brk_n    = brk;
        ext_n    = ext;
        tcnt_n   = (fall || state == IDLE) ? '0 : tcnt + 1'b1;
        cdata_n  = cdata;
        cbrk_n   = cbrk;
        cext_n   = cext;
        cvalid_n = cvalid & ~code.CODE_READY;
        perr_n   = 1'b0;
        ferr_n   = 1'b0;
        ovr_n    = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    state_n = din ? IDLE : DATA;
                    cnt_n   = '0;
                    ferr_n  = din;
                end
                DATA: begin
                    sh_n    = {din, sh[7:1]};
                    cnt_n   = cnt + 1'b1;
                    state_n = (cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = din;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    if (!din) ferr_n = 1'b1;
                    else if (!(^{sh, par})) perr_n = 1'b1;
                    else if (sh == 8'hF0) brk_n = 1'b1;
                    else if (sh == 8'hE0) ext_n = 1'b1;
                    else begin
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                        // A code loads if the register is empty or is being drained on this same edge.
                        if (!cvalid || code.CODE_READY) begin
                            cdata_n  = sh;
                            cbrk_n   = brk;
                            cext_n   = ext;
                            cvalid_n = 1'b1;
                        end else ovr_n = 1'b1;
                    end
                end
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end
        if (perr_n || ferr_n) begin
            brk_n = 1'b0;
            ext_n = 1'b0;
        end
    end
    assign code.CODE_DATA  = cdata;
    assign code.CODE_BREAK = cbrk;
    assign code.CODE_EXT   = cext;
    assign code.CODE_VALID = cvalid;
endmodule
